// File: rtl/shift_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
//   ST_W         : width of the registered controller state
//   state_t      : state register type
//   IDLE..DONE   : fixed state encodings, also used by the surrounding datapath glue
package shift_mult_pkg;

   localparam int unsigned ST_W = 4;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t IDLE    = 4'd0;
   localparam state_t ARM     = 4'd1;
   localparam state_t INIT    = 4'd2;
   localparam state_t LD_L    = 4'd3;
   localparam state_t L_SHIFT = 4'd4;
   localparam state_t LD_R    = 4'd5;
   localparam state_t R_SHIFT = 4'd6;
   localparam state_t DONE    = 4'd7;

endpackage

// File: rtl/bounded_counter.sv
// Shift-cycle counter with synchronous clear and increment.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear (wins over inc)
//   inc   : count up by one
//   count : current count
// The count saturates at all-ones instead of wrapping; the controller's shift
// limits keep it below that, so saturation only guards against misuse.
module bounded_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/shift_mult_controller.sv
// Control FSM for the shift-and-add multiplier datapath: clear, operand load,
// left normalisation, product load, right de-normalisation, completion.
// Parameters:
//   CNT_W : shift counter width
//   L_MAX : left-shift cycle limit before overflow (1..2^CNT_W-1)
//   R_MAX : right-shift cycle limit before overflow (1..2^CNT_W-1)
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start               : operation request, press-then-release
//   skip_r              : skip right-shift phase, sampled in INIT
//   a_shifting,
//   b_shifting          : left shifters still normalising
//   r_shifting          : result shifter still shifting
//   dp_clr, ld,
//   ld_l_shift,
//   ld_r_shift          : datapath load/clear strobes
//   l_shift_en,
//   r_shift_en          : shift/count enables
//   l_count, r_count    : shift cycles taken in the current operation
//   busy                : not IDLE
//   done                : one-cycle completion pulse
//   overflow            : sticky shift-limit flag, cleared in INIT
module shift_mult_controller
   import shift_mult_pkg::*;
#(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned L_MAX = 8,
   parameter int unsigned R_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             skip_r,
   input  logic             a_shifting,
   input  logic             b_shifting,
   input  logic             r_shifting,
   output logic             dp_clr,
   output logic             ld,
   output logic             ld_l_shift,
   output logic             ld_r_shift,
   output logic             l_shift_en,
   output logic             r_shift_en,
   output logic [CNT_W-1:0] l_count,
   output logic [CNT_W-1:0] r_count,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   // Count value seen during the last permitted cycle of each shift phase.
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(L_MAX - 1);
   localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_MAX - 1);

   state_t state_q, state_d;
   logic   skip_q, skip_d;
   logic   ovf_q, ovf_d;

   logic l_clr, l_inc, r_clr, r_inc;

   // Next-state logic. Inside shift states completion beats overflow.
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = ARM;
         end
         ARM: begin
            if (!start) state_d = INIT;
         end
         INIT: begin
            state_d = LD_L;
            skip_d  = skip_r;
            ovf_d   = 1'b0;
         end
         LD_L: begin
            state_d = L_SHIFT;
         end
         L_SHIFT: begin
            if (!a_shifting && !b_shifting) begin
               state_d = skip_q ? DONE : LD_R;
            end else if (l_count == L_LAST) begin
               state_d = DONE;
               ovf_d   = 1'b1;
            end
         end
         LD_R: begin
            state_d = R_SHIFT;
         end
         R_SHIFT: begin
            if (!r_shifting) begin
               state_d = DONE;
            end else if (r_count == R_LAST) begin
               state_d = DONE;
               ovf_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         skip_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         ovf_q   <= ovf_d;
      end
   end

   // Moore output decode.
   always_comb begin
      dp_clr     = 1'b0;
      ld         = 1'b0;
      ld_l_shift = 1'b0;
      ld_r_shift = 1'b0;
      l_shift_en = 1'b0;
      r_shift_en = 1'b0;
      done       = 1'b0;
      case (state_q)
         ARM:     dp_clr     = 1'b1;
         INIT:    ld         = 1'b1;
         LD_L:    ld_l_shift = 1'b1;
         LD_R:    ld_r_shift = 1'b1;
         L_SHIFT: l_shift_en = 1'b1;
         R_SHIFT: r_shift_en = 1'b1;
         DONE:    done       = 1'b1;
         default: ;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign overflow = ovf_q;

   // r_count is also cleared in INIT so a skipped right phase reports zero.
   assign l_clr = (state_q == LD_L);
   assign l_inc = (state_q == L_SHIFT);
   assign r_clr = (state_q == INIT) || (state_q == LD_R);
   assign r_inc = (state_q == R_SHIFT);

   bounded_counter #(
      .CNT_W (CNT_W)
   ) u_l_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (l_clr),
      .inc   (l_inc),
      .count (l_count)
   );

   bounded_counter #(
      .CNT_W (CNT_W)
   ) u_r_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (r_clr),
      .inc   (r_inc),
      .count (r_count)
   );

endmodule

// File: tb/tb_shift_mult_controller.sv
// Self-checking bench for shift_mult_controller. Each operation is described by
// its phase list (derived from the start/shifting stimulus); every cycle the
// outputs are compared against the decode of the expected phase plus counters.
module tb_shift_mult_controller;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned L_MAX = 8;
   localparam int unsigned R_MAX = 8;

   typedef enum int {P_IDLE, P_ARM, P_INIT, P_LDL, P_LSH, P_LDR, P_RSH, P_DONE} phase_e;

   logic             clk = 1'b0;
   logic             rst, start, skip_r, a_shifting, b_shifting, r_shifting;
   logic             dp_clr, ld, ld_l_shift, ld_r_shift, l_shift_en, r_shift_en;
   logic [CNT_W-1:0] l_count, r_count;
   logic             busy, done, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: counters and sticky flag as the operation has left them.
   int m_l   = 0;
   int m_r   = 0;
   bit m_ovf = 1'b0;

   logic [16:0] obs_vec;
   assign obs_vec = {dp_clr, ld, ld_l_shift, ld_r_shift, l_shift_en, r_shift_en, busy, done,
                     overflow, l_count, r_count};

   shift_mult_controller #(
      .CNT_W (CNT_W),
      .L_MAX (L_MAX),
      .R_MAX (R_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .skip_r     (skip_r),
      .a_shifting (a_shifting),
      .b_shifting (b_shifting),
      .r_shifting (r_shifting),
      .dp_clr     (dp_clr),
      .ld         (ld),
      .ld_l_shift (ld_l_shift),
      .ld_r_shift (ld_r_shift),
      .l_shift_en (l_shift_en),
      .r_shift_en (r_shift_en),
      .l_count    (l_count),
      .r_count    (r_count),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [16:0] exp_vec(input phase_e ph);
      logic [7:0] ctl;
      case (ph)
         P_IDLE:  ctl = 8'b0000_0000;
         P_ARM:   ctl = 8'b1000_0010;
         P_INIT:  ctl = 8'b0100_0010;
         P_LDL:   ctl = 8'b0010_0010;
         P_LDR:   ctl = 8'b0001_0010;
         P_LSH:   ctl = 8'b0000_1010;
         P_RSH:   ctl = 8'b0000_0110;
         default: ctl = 8'b0000_0011;
      endcase
      return {ctl, m_ovf, 4'(m_l), 4'(m_r)};
   endfunction

   // One clock cycle in phase ph: check outputs, then drive inputs for the edge.
   task automatic cyc(input string name, input phase_e ph, input logic st, input logic sk,
                      input logic a, input logic b, input logic r, input logic rs);
      @(negedge clk);
      check($sformatf("%s/%s", name, ph.name()), {15'd0, obs_vec}, {15'd0, exp_vec(ph)});
      start      = st;
      skip_r     = sk;
      a_shifting = a;
      b_shifting = b;
      r_shifting = r;
      rst        = rs;
      if (rs) begin
         m_l = 0; m_r = 0; m_ovf = 1'b0;
      end else begin
         case (ph)
            P_INIT: begin m_ovf = 1'b0; m_r = 0; end
            P_LDL:  m_l = 0;
            P_LSH:  m_l++;
            P_LDR:  m_r = 0;
            P_RSH:  m_r++;
            default: ;
         endcase
      end
   endtask

   // One operation. h: total cycles start is high before release; ad/bd/rd: shift
   // cycle on which each shifting flag is first seen low; hold keeps start high
   // from INIT onward; rst_k>0 pulses reset on that R_SHIFT cycle.
   task automatic run_op(input string name, input int h, input bit skip, input int ad,
                         input int bd, input int rd, input bit hold, input int rst_k);
      int nl, nr;
      bit ovl, ovr;
      cyc(name, P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < h; i++) cyc(name, P_ARM, (i < h - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(name, P_INIT, hold, skip, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(name, P_LDL, hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nl  = (ad > bd) ? ad : bd;
      ovl = (nl > int'(L_MAX));
      if (ovl) nl = L_MAX;
      for (int k = 1; k <= nl; k++) cyc(name, P_LSH, hold, 1'b0, (k < ad), (k < bd), 1'b0, 1'b0);
      if (ovl) m_ovf = 1'b1;
      if (!ovl && !skip) begin
         cyc(name, P_LDR, hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         nr  = rd;
         ovr = (nr > int'(R_MAX));
         if (ovr) nr = R_MAX;
         for (int k = 1; k <= nr; k++) begin
            if (k == rst_k) begin
               cyc(name, P_RSH, 1'b0, 1'b0, 1'b0, 1'b0, (k < rd), 1'b1);
               return;
            end
            cyc(name, P_RSH, hold, 1'b0, 1'b0, 1'b0, (k < rd), 1'b0);
         end
         if (ovr) m_ovf = 1'b1;
      end
      cyc(name, P_DONE, hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_cycle(input string name, input logic st, input logic rs);
      cyc(name, P_IDLE, st, 1'b0, 1'b0, 1'b0, 1'b0, rs);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; skip_r = 1'b0;
      a_shifting = 1'b0; b_shifting = 1'b0; r_shifting = 1'b0;
      @(posedge clk);
      idle_cycle("reset", 1'b1, 1'b1);   // reset wins over start
      idle_cycle("reset", 1'b0, 1'b0);

      run_op("minimum", 1, 1'b0, 1, 1, 1, 1'b0, 0);
      run_op("basic", 3, 1'b0, 3, 3, 2, 1'b0, 0);
      @(negedge clk);
      check("basic_lcnt_after", {28'd0, l_count}, 32'd3);
      check("basic_rcnt_after", {28'd0, r_count}, 32'd2);
      check("basic_ovf_after", {31'd0, overflow}, 32'd0);

      run_op("skip", 2, 1'b1, 2, 4, 3, 1'b0, 0);
      run_op("asym", 1, 1'b0, 1, 5, 1, 1'b0, 0);
      run_op("l_edge", 1, 1'b0, L_MAX, 1, R_MAX, 1'b0, 0);
      run_op("l_ovf", 2, 1'b0, 20, 1, 1, 1'b0, 0);
      idle_cycle("ovf_sticky", 1'b0, 1'b0);
      run_op("ovf_clear", 1, 1'b0, 2, 2, 2, 1'b0, 0);
      run_op("r_ovf", 1, 1'b0, 1, 1, 30, 1'b0, 0);
      idle_cycle("ovf_rst", 1'b0, 1'b1);
      idle_cycle("ovf_rst", 1'b0, 1'b0);
      run_op("mid_rst", 1, 1'b0, 2, 3, 6, 1'b0, 3);
      idle_cycle("mid_rst", 1'b0, 1'b0);

      // Start held through DONE: the next op parks in ARM for several cycles.
      run_op("held_a", 2, 1'b0, 2, 1, 2, 1'b1, 0);
      run_op("held_b", 6, 1'b0, 1, 3, 1, 1'b0, 0);

      for (int it = 0; it < 60; it++) begin
         int gap;
         run_op("rand", $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                $urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(1, 10),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2 : 0);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle("rand_gap", 1'b0, 1'b0);
      end
      idle_cycle("final", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_mult_controller.md
# shift_mult_controller

Parametrised successor of the shift-and-add multiplier control FSM. It sequences the datapath through these phases:

- datapath clear,
- operand load,
- left normalisation of both operands,
- product load,
- right de-normalisation of the result.

Additions over the previous generation: internal bounded shift counters, a runaway-shift overflow guard, a mode that skips the right-shift phase, and a `busy` status. It sits between the top-level start/done interface and the shifter/multiplier datapath.

## Interface
- `CNT_W`, 4: width of the left and right shift counters.
- `L_MAX`, 8: maximum left-shift cycles before overflow; 1 ≤ L_MAX ≤ 2^CNT_W−1.
- `R_MAX`, 8: maximum right-shift cycles before overflow; 1 ≤ R_MAX ≤ 2^CNT_W−1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; press-then-release protocol.
- `skip_r`  in  1  skip right-shift phase; sampled only in INIT.
- `a_shifting`, `b_shifting`  in  1 each  left shifters still normalising.
- `r_shifting`  in  1  result shifter still shifting.
- `dp_clr`  out  1  datapath register clear.
- `ld`  out  1  load operands.
- `ld_l_shift`  out  1  load left shifters.
- `ld_r_shift`  out  1  load right shifter.
- `l_shift_en`, `r_shift_en`  out  1 each  shift/count enables.
- `l_count`, `r_count`  out  CNT_W each  shift cycles taken in the current operation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky; a shift phase hit its limit.

## Operation
- State is registered, 4-bit. All control outputs are Moore decodes of the present state.
- Next state:
  - IDLE: to ARM if `start`.
  - ARM: stays while `start`; to INIT on `start`=0.
  - INIT: to LD_L; latches `skip_r`.
  - LD_L: to L_SHIFT.
  - L_SHIFT: to LD_R (or DONE if latched `skip_r`) when `a_shifting`=`b_shifting`=0. Otherwise, if `l_count`==L_MAX−1, to DONE with `overflow` set. Otherwise stays.
  - LD_R: to R_SHIFT.
  - R_SHIFT: to DONE when `r_shifting`=0. Otherwise, if `r_count`==R_MAX−1, to DONE with `overflow` set. Otherwise stays.
  - DONE: to IDLE unconditionally.
- Output decodes:
  - `dp_clr` in ARM.
  - `ld` in INIT.
  - `ld_l_shift` in LD_L.
  - `ld_r_shift` in LD_R.
  - `l_shift_en` in L_SHIFT; `r_shift_en` in R_SHIFT.
  - `done` in DONE.
- Transition priority inside shift states: completion, then overflow, then stay.
- Counters:
  - `l_count` clears in LD_L and increments every L_SHIFT cycle.
  - `r_count` clears in LD_R and increments every R_SHIFT cycle.
  - Both hold elsewhere and never wrap; the L_MAX/R_MAX bound precludes it.
- `overflow` clears on INIT. It is set on the overflow transition and held through IDLE until the next INIT.
- Skipped right phase: `r_count` holds its INIT-cleared value 0; `ld_r_shift`/`r_shift_en` never assert.

## Timing
- Reset: the state is IDLE one edge after `rst`=1 is sampled. The following are 0 from that edge, regardless of current state:
  - all outputs,
  - `l_count`/`r_count`,
  - `overflow`,
  - the latched `skip_r`.
- `rst` dominates `start` on the same edge.
- `start` release to `ld`: 1 cycle (ARM→INIT edge).
- Minimum operation: shifters idle immediately, no skip. The sequence is IDLE, ARM, INIT, LD_L, L_SHIFT(1), LD_R, R_SHIFT(1), DONE.
- `start` held high through DONE: FSM goes DONE→IDLE→ARM and waits for release. No back-to-back operation without a release.
- `a_shifting` deasserted while `b_shifting` is still high: stay in L_SHIFT. Both must be low in the same cycle.
- `done` is exactly one cycle wide. `busy` falls on the cycle after `done`.

## Structure
- Shared package `shift_mult_pkg`: state encodings as localparams (IDLE=0, ARM=1, INIT=2, LD_L=3, L_SHIFT=4, LD_R=5, R_SHIFT=6, DONE=7); width constant `ST_W`=4.
- One sub-module, `bounded_counter` (CNT_W, clr, inc, count), instantiated twice for the left and right counters.
- The state register, next-state logic and output decode stay in the top module.

## Test plan
- Basic flow: `start` 1 for 3 cycles then 0; `a_shifting`/`b_shifting` high 3 cycles in L_SHIFT; `r_shifting` high 2 cycles.
  - Required: `l_count`=3 and `r_count`=2 at DONE.
  - Required: `done` for one cycle, `overflow`=0.
- Skip mode: `skip_r`=1 during INIT.
  - Required: L_SHIFT→DONE; `ld_r_shift`/`r_shift_en` never high; `r_count`=0.
- Left overflow: L_MAX=8, `a_shifting` stuck high.
  - Required: exactly 8 L_SHIFT cycles, then DONE with `overflow`=1.
  - Required: `overflow` still 1 in IDLE; cleared in INIT of the next run.
- Asymmetric shift: `a_shifting` low after 1 cycle, `b_shifting` low after 5 cycles.
  - Required: leave L_SHIFT only after cycle 5, `l_count`=5.
- Mid-operation reset: `rst` pulsed during R_SHIFT.
  - Required: IDLE on the next edge; all outputs, counters and `overflow` 0; `busy`=0.
- Start held: `start` high continuously across a full run.
  - Required: after DONE, FSM parks in ARM until `start` falls; no second `ld` until then.
